// File: rtl/jk_mod_counter.sv
// jk_mod_counter
//   Modulo-MODULUS up/down counter whose state bits are JK flops. Every cycle
//   the per-bit J/K drive is computed from the current count and the controls.
//   It is applied on the falling clock edge, the same edge that updates q.
//   Load has priority over count enable. tc/carry allow cascading: drive the
//   next counter's en from this counter's carry.
//
// Parameters
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, legal range 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk      clock, all state changes on the falling edge
//   rst      asynchronous active-high reset (q=0, wrap=0, ovf=0)
//   en       count enable
//   up       direction, 1 = increment, 0 = decrement
//   load     synchronous parallel load (clamped to MODULUS-1)
//   din      load value
//   q        registered count
//   jk_j     per-bit J drive for the coming edge
//   jk_k     per-bit K drive for the coming edge
//   tc       terminal count for the current direction (not gated by en)
//   carry    en & tc & ~load, cascade enable for the next stage
//   wrap     one-cycle pulse after an edge that wrapped
//   ovf      sticky wrap flag          (only with JKCNT_OVF_STICKY_EN)
//   ovf_clr  clears ovf when no wrap   (only with JKCNT_OVF_STICKY_EN)
//
// Optional feature macro: JKCNT_OVF_STICKY_EN
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef JKCNT_OVF_STICKY_EN
  input  logic             ovf_clr,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             tc,
  output logic             carry,
  output logic             wrap
`ifdef JKCNT_OVF_STICKY_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > 30 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // Out-of-range load values saturate to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Characteristic JK equation: Q+ = J&~Q | ~K&Q.
  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] j,
                                                input logic [WIDTH-1:0] k);
    return (j & ~cur) | (~k & cur);
  endfunction

  logic [WIDTH-1:0] q_nxt_p0;

  // Stage p0: next count, JK drive, terminal count and cascade carry
  always_comb begin
    q_nxt_p0 = q;
    if (load) begin
      q_nxt_p0 = clamp_load(din);
    end else if (en) begin
      if (up) q_nxt_p0 = (q == MAX_V) ? '0 : q + ONE;
      else    q_nxt_p0 = (q == '0)    ? MAX_V : q - ONE;
    end
  end

  // Changed bits toggle (11), unchanged bits hold (00); a hold cycle
  // therefore drives all zeros.
  assign jk_j  = q ^ q_nxt_p0;
  assign jk_k  = q ^ q_nxt_p0;
  assign tc    = up ? (q == MAX_V) : (q == '0);
  assign carry = en & tc & ~load;

  // Stage p1: JK state bits and wrap pulse, falling edge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= jk_apply(q, jk_j, jk_k);
      wrap <= carry;
    end
  end

`ifdef JKCNT_OVF_STICKY_EN
  // A wrap on the same edge as ovf_clr keeps the flag set.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (carry)   ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0, ovf_clr = 1'b0, c_en = 1'b0;
  logic [3:0] din = '0;

  logic [3:0] q, jk_j, jk_k, q16, jj16, jk16, lo_q, lo_j, lo_k, hi_q, hi_j, hi_k;
  logic       tc, carry, wrap, tc16, carry16, wrap16;
  logic       lo_tc, lo_carry, lo_wrap, hi_tc, hi_carry, hi_wrap;
  logic       ovf, ovf16, ovf_lo, ovf_hi;
  logic       zero = 1'b0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
`ifdef JKCNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf),
`endif
    .q(q), .jk_j(jk_j), .jk_k(jk_k), .tc(tc), .carry(carry), .wrap(wrap));

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
`ifdef JKCNT_OVF_STICKY_EN
    .ovf_clr(zero), .ovf(ovf16),
`endif
    .q(q16), .jk_j(jj16), .jk_k(jk16), .tc(tc16), .carry(carry16), .wrap(wrap16));

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .load(1'b0), .din(4'd0),
`ifdef JKCNT_OVF_STICKY_EN
    .ovf_clr(zero), .ovf(ovf_lo),
`endif
    .q(lo_q), .jk_j(lo_j), .jk_k(lo_k), .tc(lo_tc), .carry(lo_carry), .wrap(lo_wrap));

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst(rst), .en(lo_carry), .up(1'b1), .load(1'b0), .din(4'd0),
`ifdef JKCNT_OVF_STICKY_EN
    .ovf_clr(zero), .ovf(ovf_hi),
`endif
    .q(hi_q), .jk_j(hi_j), .jk_k(hi_k), .tc(hi_tc), .carry(hi_carry), .wrap(hi_wrap));

  typedef struct {
    int q10; bit w10; int q16; bit w16;
    int lo; int hi; bit wlo; bit whi; bit ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  // reference state
  int mq = 0, m16 = 0, cnt = 0;
  bit mo = 0;
  bit clr = 0, cen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Count rules expressed as modular arithmetic.
  task automatic model_step(input int m, input int cq, input bit e, input bit u,
                            input bit l, input int d, output int nq, output bit w);
    w  = 0;
    nq = cq;
    if (l) nq = (d > m - 1) ? m - 1 : d;
    else if (e && u) begin nq = (cq + 1) % m;     w = (cq + 1 == m); end
    else if (e)      begin nq = (cq + m - 1) % m; w = (cq == 0);     end
  endtask

  task automatic model_reset();
    mq = 0; m16 = 0; cnt = 0; mo = 0;
  endtask

  // Called at posedge+1; drives one falling edge worth of stimulus.
  task automatic step(input bit e, input bit u, input bit l, input int d);
    exp_t x;
    int   n;
    bit   w;
    en = e; up = u; load = l; din = d[3:0]; ovf_clr = clr; c_en = cen;
    #1;
    model_step(10, mq, e, u, l, d, n, w);
    chk("tc", tc, u ? (mq == 9) : (mq == 0));
    chk("carry", carry, w);
    chk("jk_j", jk_j, mq ^ n);
    chk("jk_k", jk_k, mq ^ n);
    mq = n; x.q10 = n; x.w10 = w;
    if (w) mo = 1; else if (clr) mo = 0;
    x.ovf = mo;
    model_step(16, m16, e, u, l, d, n, w);
    chk("tc16", tc16, u ? (m16 == 15) : (m16 == 0));
    chk("jk16", jj16, m16 ^ n);
    m16 = n; x.q16 = n; x.w16 = w;
    if (cen) begin
      chk("lo_carry", lo_carry, (cnt % 10) == 9);
      x.wlo = (cnt % 10) == 9;
      x.whi = (cnt == 99);
      cnt = (cnt + 1) % 100;
    end else begin
      chk("lo_carry", lo_carry, 0);
      x.wlo = 0; x.whi = 0;
    end
    x.lo = cnt % 10; x.hi = cnt / 10;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  // Monitor: every falling edge that has an outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk); #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q", q, x.q10);
        chk("wrap", wrap, x.w10);
        chk("q16", q16, x.q16);
        chk("wrap16", wrap16, x.w16);
        chk("lo_q", lo_q, x.lo);
        chk("hi_q", hi_q, x.hi);
        chk("lo_wrap", lo_wrap, x.wlo);
        chk("hi_wrap", hi_wrap, x.whi);
`ifdef JKCNT_OVF_STICKY_EN
        chk("ovf", ovf, x.ovf);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap, 0);
    rst = 1'b0;
    model_reset();

    // up count from 0 through the 9->0 wrap
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    // idle cycles hold the sticky flag
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

    // load 9, then wrap while clearing: set wins
    step(0, 1, 1, 9);
    clr = 1;
    step(1, 1, 0, 0);
    // clear on a non-wrapping edge
    step(0, 1, 0, 0);
    clr = 0;

    // load priority and clamp
    step(1, 1, 1, 5);
    step(1, 0, 1, 12);
    step(0, 1, 1, 15);

    // down wrap from 0
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // direction change mid-count
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);

    // asynchronous reset mid-cycle with q = 7
    step(0, 1, 1, 7);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_wrap", wrap, 0);
    model_reset();
    @(negedge clk); #1;
    chk("rst_hold_q", q, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 1, 0, 0);

    // cascade: 100 edges from 00
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cen = 1;
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0);
    cen = 0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      clr = ($urandom_range(7) == 0);
      cen = ($urandom_range(1) == 1);
      step($urandom_range(3) != 0, $urandom_range(1) == 1,
           $urandom_range(7) == 0, int'($urandom_range(15)));
    end
    clr = 0; cen = 0;
    step(0, 1, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
